// File: rtl/prio_codec_pkg.sv
// Shared types and helpers for the 8-to-3 priority encoder / 3-to-8 decoder pair.
// Both sides of the link import this package.
package prio_codec_pkg;

  localparam int CODE_W = 3;
  localparam int VEC_W  = 8;

  typedef enum logic {IDLE, HOLD} state_t;

  // Bit 0 of the vector is the leftmost element, so code 0 lands on v[0].
  function automatic logic [0:VEC_W-1] onehot3to8(input logic [CODE_W-1:0] code);
    logic [0:VEC_W-1] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/priority_decoder_hold_if.sv
// Code-in / strobe-out link between an encoded-index source and the hold decoder.
interface priority_decoder_hold_if;
  import prio_codec_pkg::*;

  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              code_ready;
  logic [0:VEC_W-1]  y;
  logic              y_valid;
  logic              done;

  modport master (output code_in, code_valid, input code_ready, y, y_valid, done);
  modport slave  (input code_in, code_valid, output code_ready, y, y_valid, done);

endinterface

// File: rtl/onehot_decode_3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module onehot_decode_3to8
  import prio_codec_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              en,
  output logic [0:VEC_W-1]  vec
);

  for (genvar gi = 0; gi < VEC_W; gi++) begin : g_line
    assign vec[gi] = en && (code == CODE_W'(gi));
  end

endmodule

// File: rtl/priority_decoder_hold.sv
// Rebuilds a one-hot strobe from an encoded index and holds it for HOLD_CYCLES cycles.
// A new code may be accepted on the last hold cycle so consecutive strobes abut.
module priority_decoder_hold
  import prio_codec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  priority_decoder_hold_if.slave  bus
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [0:VEC_W-1] y_reg;
  logic             y_valid_reg;
  logic             done_reg;

  logic             take;
  logic [0:VEC_W-1] dec_vec;

  // cnt_reg is zero in IDLE and on the last hold cycle, which are exactly the accept windows.
  assign bus.code_ready = (state_reg == IDLE) || (cnt_reg == '0);
  assign take           = bus.code_valid && bus.code_ready;

  onehot_decode_3to8 u_decode (
    .code (bus.code_in),
    .en   (take),
    .vec  (dec_vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (take) begin
            state_reg   <= HOLD;
            cnt_reg     <= RELOAD;
            y_reg       <= dec_vec;
            y_valid_reg <= 1'b1;
            done_reg    <= (HOLD_CYCLES == 1);
          end
        end
        HOLD: begin
          if (cnt_reg != '0) begin
            cnt_reg  <= cnt_reg - CNT_W'(1);
            done_reg <= (cnt_reg == CNT_W'(1));
          end else if (take) begin
            cnt_reg     <= RELOAD;
            y_reg       <= dec_vec;
            y_valid_reg <= 1'b1;
            done_reg    <= (HOLD_CYCLES == 1);
          end else begin
            state_reg   <= IDLE;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          y_reg       <= '0;
          y_valid_reg <= 1'b0;
          done_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.y       = y_reg;
  assign bus.y_valid = y_valid_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_priority_decoder_hold.sv
// Scoreboard bench: two decoders (hold 4 and hold 1) driven by directed codes,
// a negedge monitor pops expected codes and checks strobe, done and ready.
module tb_priority_decoder_hold;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ci [2];
  logic       cv [2];

  int tests = 0;
  int fails = 0;

  int hold_len [2] = '{4, 1};
  int hidx     [2] = '{0, 0};
  logic [2:0] cur [2];
  logic [2:0] q0 [$];
  logic [2:0] q1 [$];

  logic rst_q = 1'b0;
  logic armed = 1'b0;

  always #5 clk = ~clk;

  priority_decoder_hold_if bus0 ();
  priority_decoder_hold_if bus1 ();

  assign bus0.code_in    = ci[0];
  assign bus0.code_valid = cv[0];
  assign bus1.code_in    = ci[1];
  assign bus1.code_valid = cv[1];

  priority_decoder_hold #(.HOLD_CYCLES(4), .CNT_W(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  priority_decoder_hold #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  always @(posedge clk) begin
    rst_q <= rst;
    if (rst) armed <= 1'b1;
  end

  task automatic chk(input string nm, input int d, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s dut%0d t=%0t got %b expected %b", nm, d, $time, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int d, input logic [2:0] c);
    if (d == 0) q0.push_back(c); else q1.push_back(c);
  endtask

  task automatic qpop(input int d, output logic [2:0] c);
    if (d == 0) c = q0.pop_front(); else c = q1.pop_front();
  endtask

  task automatic qflush(input int d);
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  task automatic check_dut(input int d, input logic [0:7] y, input logic yv,
                           input logic dn, input logic rdy);
    logic [0:7] e;
    logic       last;
    if (rst_q) begin
      chk("rst_y", d, y, 8'h00);
      chk("rst_y_valid", d, {7'd0, yv}, 8'd0);
      chk("rst_done", d, {7'd0, dn}, 8'd0);
      qflush(d);
      hidx[d] = 0;
      return;
    end
    if (hidx[d] != 0 || qsize(d) != 0) begin
      chk("y_valid_active", d, {7'd0, yv}, 8'd1);
      if (hidx[d] == 0) qpop(d, cur[d]);
      e = '0;
      e[cur[d]] = 1'b1;
      last = (hidx[d] == hold_len[d] - 1);
      chk("y_onehot", d, y, e);
      chk("y_popcount", d, 8'($countones(y)), 8'd1);
      chk("done_pulse", d, {7'd0, dn}, {7'd0, last});
      chk("ready_hold", d, {7'd0, rdy}, {7'd0, last});
      hidx[d] = last ? 0 : hidx[d] + 1;
    end else begin
      chk("y_idle", d, y, 8'h00);
      chk("y_valid_idle", d, {7'd0, yv}, 8'd0);
      chk("done_idle", d, {7'd0, dn}, 8'd0);
      chk("ready_idle", d, {7'd0, rdy}, 8'd1);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check_dut(0, bus0.y, bus0.y_valid, bus0.done, bus0.code_ready);
      check_dut(1, bus1.y, bus1.y_valid, bus1.done, bus1.code_ready);
    end
  end

  // Presents a code and leaves code_valid high; returns just after the accepting edge.
  task automatic send(input int d, input logic [2:0] c);
    bit ok;
    logic rdy;
    ok = 0;
    ci[d] = c;
    cv[d] = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      #1;
      rdy = (d == 0) ? bus0.code_ready : bus1.code_ready;
      if (rdy && !rst) begin
        ok = 1;
        qpush(d, c);
        $display("[TB] dut%0d accept code %0d", d, c);
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL accept_timeout dut%0d code %0d got no ready expected ready", d, c);
    end
  endtask

  task automatic idle(input int n);
    cv[0] = 1'b0;
    cv[1] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ci[0] = 3'd0; ci[1] = 3'd0;
    cv[0] = 1'b0; cv[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Quiet idle after reset
    idle(10);

    // Single code, one-cycle valid
    send(0, 3'b101);
    idle(8);

    // Back-to-back: second code held until accepted on the last hold cycle
    send(0, 3'b000);
    send(0, 3'b111);
    idle(8);

    // Hold of one: full-rate stream 0..7
    for (int c = 0; c < 8; c++) send(1, 3'(c));
    idle(4);

    // Reset during hold cycle 2
    send(0, 3'b010);
    cv[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    send(0, 3'b110);
    idle(8);

    // Every code on both instances
    for (int c = 0; c < 8; c++) begin
      send(0, 3'(c));
      idle(6);
    end
    for (int c = 0; c < 8; c++) begin
      send(1, 3'(c));
      idle(2);
    end

    idle(10);
    chk("drain_q", 0, 8'(qsize(0)), 8'd0);
    chk("drain_q", 1, 8'(qsize(1)), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
